// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
//   Shared types for the pipeline hazard controller.
//   fwd_sel_t  : E-stage operand source select (also decoded by the
//                execute_cycle operand mux).
//   mc_state_t : multi-cycle (mul/div) freeze state.
// ---------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,   // operand from register file
        FWD_W  = 2'b01,   // operand from ResultW
        FWD_M  = 2'b10    // operand from ALU_ResultM
    } fwd_sel_t;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

endpackage

// File: rtl/hazard_sat_counter.sv
// ---------------------------------------------------------------------------
// hazard_sat_counter
//   Saturating up-counter used for stall/flush performance events.
//   Ports:
//     clk   in   core clock
//     rst   in   asynchronous active-low reset (clears the count)
//     inc   in   count one event this cycle
//     count out  current value; holds at all-ones
// ---------------------------------------------------------------------------
module hazard_sat_counter
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_unit
//   Hazard controller for the 5-stage RV32 pipeline. Produces E-stage
//   forwarding selects, load-use / RAW stalls, branch flushes and the
//   multi-cycle-op freeze, plus saturating stall/flush event counters.
//   Hazard outputs are combinational (same-cycle); counters are registered.
//   Every output reads 0 while rst is low.
//   Ports:
//     clk, rst                    clock, asynchronous active-low reset
//     Rs1_D, Rs2_D                source regs of the D-stage instruction
//     Rs1_E, Rs2_E, RD_E          source/dest regs of the E-stage instruction
//     RegWriteE, ResultSrcE       E writes RF / E is a load
//     MCStartE                    E holds a multi-cycle op (level)
//     PCSrcE                      branch/jump taken in E
//     RD_M, RegWriteM             M-stage dest reg / write enable
//     RD_W, RegWriteW             W-stage dest reg / write enable
//     ForwardAE, ForwardBE        operand selects (00 RF, 10 M, 01 W)
//     StallF, StallD, StallE      hold PC / IF-ID / ID-EX
//     FlushD, FlushE, FlushM      bubble into IF-ID / ID-EX / EX-MEM
//     MCBusy                      multi-cycle freeze active
//     StallCnt, FlushCnt          saturating event counters
// ---------------------------------------------------------------------------
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int AW     = 5,
    parameter int MC_LAT = 4,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    Rs1_D,
    input  logic [AW-1:0]    Rs2_D,
    input  logic [AW-1:0]    Rs1_E,
    input  logic [AW-1:0]    Rs2_E,
    input  logic [AW-1:0]    RD_E,
    input  logic             RegWriteE,
    input  logic             ResultSrcE,
    input  logic             MCStartE,
    input  logic             PCSrcE,
    input  logic [AW-1:0]    RD_M,
    input  logic [AW-1:0]    RD_W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             MCBusy,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam int              MC_W    = $clog2(MC_LAT) + 1;
    localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MC_LAT - 1);

    mc_state_t       r_mc_state;
    logic [MC_W-1:0] r_mc_cnt;

    fwd_sel_t w_fwd_a;
    fwd_sel_t w_fwd_b;
    logic     w_ld_use;
    logic     w_raw;
    logic     w_d_hazard;
    logic     w_mc_start;
    logic     w_mc_busy;
    logic     w_flush_evt;

    // M has the younger result, so it wins over W; x0 is never forwarded.
    function automatic fwd_sel_t fwd_pick(
        input logic [AW-1:0] rs,
        input logic          rw_m,
        input logic [AW-1:0] rd_m,
        input logic          rw_w,
        input logic [AW-1:0] rd_w
    );
        if ((FWD_EN == 0) || (rs == '0)) return FWD_RF;
        if (rw_m && (rd_m == rs))        return FWD_M;
        if (rw_w && (rd_w == rs))        return FWD_W;
        return FWD_RF;
    endfunction

    function automatic logic src_hit(
        input logic [AW-1:0] rs,
        input logic          we,
        input logic [AW-1:0] rd
    );
        return we && (rd != '0) && (rd == rs);
    endfunction

    assign w_fwd_a = fwd_pick(Rs1_E, RegWriteM, RD_M, RegWriteW, RD_W);
    assign w_fwd_b = fwd_pick(Rs2_E, RegWriteM, RD_M, RegWriteW, RD_W);

    // With forwarding only a load result is too late for the next instruction.
    assign w_ld_use = (FWD_EN != 0) && ResultSrcE &&
                      (src_hit(Rs1_D, RegWriteE, RD_E) || src_hit(Rs2_D, RegWriteE, RD_E));

    // Interlock-only: any pending E/M write to a D source must drain first.
    // W is safe because the register file writes in the first half-cycle.
    assign w_raw = (FWD_EN == 0) &&
                   (src_hit(Rs1_D, RegWriteE, RD_E) || src_hit(Rs1_D, RegWriteM, RD_M) ||
                    src_hit(Rs2_D, RegWriteE, RD_E) || src_hit(Rs2_D, RegWriteM, RD_M));

    assign w_d_hazard = w_ld_use || w_raw;

    // Freeze starts in the cycle MCStartE is first seen. The cycle where the
    // counter reads 1 is the release cycle: E completes and MCStartE (possibly
    // still high from the same op) is ignored because the FSM is not idle.
    assign w_mc_start = (r_mc_state == MC_IDLE) && MCStartE && (MC_LAT > 1);
    assign w_mc_busy  = w_mc_start || ((r_mc_state == MC_BUSY) && (r_mc_cnt > MC_W'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mc_state <= MC_IDLE;
            r_mc_cnt   <= '0;
        end else begin
            case (r_mc_state)
                MC_IDLE: begin
                    if (w_mc_start) begin
                        r_mc_state <= MC_BUSY;
                        r_mc_cnt   <= MC_LOAD;
                    end
                end
                MC_BUSY: begin
                    r_mc_cnt <= r_mc_cnt - MC_W'(1);
                    if (r_mc_cnt == MC_W'(1)) begin
                        r_mc_state <= MC_IDLE;
                    end
                end
                default: begin
                    r_mc_state <= MC_IDLE;
                    r_mc_cnt   <= '0;
                end
            endcase
        end
    end

    // Priority: multi-cycle freeze > branch flush > D-stage data hazard.
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        MCBusy    = 1'b0;
        if (rst) begin
            ForwardAE = w_fwd_a;
            ForwardBE = w_fwd_b;
            MCBusy    = w_mc_busy;
            if (w_mc_busy) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (w_d_hazard) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    assign w_flush_evt = PCSrcE && !w_mc_busy;

    hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (StallF),
        .count (StallCnt)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_flush_evt),
        .count (FlushCnt)
    );

    a_no_x: assert property (@(posedge clk) disable iff (!rst)
        !$isunknown({ForwardAE, ForwardBE, StallF, StallD, StallE,
                     FlushD, FlushE, FlushM, MCBusy, StallCnt, FlushCnt}));

    a_flush_stall_e: assert property (@(posedge clk) disable iff (!rst)
        !(FlushE && StallE));

    // A taken branch cannot come from a multi-cycle op in E.
    a_pc_vs_mc: assert property (@(posedge clk) disable iff (!rst)
        !(PCSrcE && MCStartE));

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
    logic       RegWriteE, ResultSrcE, MCStartE, PCSrcE, RegWriteM, RegWriteW;

    // Instance A: forwarding, MC_LAT=4. Instance B: interlock-only, MC_LAT=1, 3-bit counters.
    logic [1:0]  ForwardAE_a, ForwardBE_a, ForwardAE_b, ForwardBE_b;
    logic        StallF_a, StallD_a, StallE_a, FlushD_a, FlushE_a, FlushM_a, MCBusy_a;
    logic        StallF_b, StallD_b, StallE_b, FlushD_b, FlushE_b, FlushM_b, MCBusy_b;
    logic [15:0] StallCnt_a, FlushCnt_a;
    logic [2:0]  StallCnt_b, FlushCnt_b;
    logic [10:0] outA, outB;

    assign outA = {ForwardAE_a, ForwardBE_a, StallF_a, StallD_a, StallE_a, FlushD_a, FlushE_a, FlushM_a, MCBusy_a};
    assign outB = {ForwardAE_b, ForwardBE_b, StallF_b, StallD_b, StallE_b, FlushD_b, FlushE_b, FlushM_b, MCBusy_b};

    hazard_ctrl_unit #(.AW(5), .MC_LAT(4), .FWD_EN(1), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .RD_E(RD_E),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MCStartE(MCStartE), .PCSrcE(PCSrcE),
        .RD_M(RD_M), .RD_W(RD_W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ForwardAE(ForwardAE_a), .ForwardBE(ForwardBE_a),
        .StallF(StallF_a), .StallD(StallD_a), .StallE(StallE_a),
        .FlushD(FlushD_a), .FlushE(FlushE_a), .FlushM(FlushM_a), .MCBusy(MCBusy_a),
        .StallCnt(StallCnt_a), .FlushCnt(FlushCnt_a)
    );

    hazard_ctrl_unit #(.AW(5), .MC_LAT(1), .FWD_EN(0), .CNT_W(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .RD_E(RD_E),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MCStartE(MCStartE), .PCSrcE(PCSrcE),
        .RD_M(RD_M), .RD_W(RD_W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ForwardAE(ForwardAE_b), .ForwardBE(ForwardBE_b),
        .StallF(StallF_b), .StallD(StallD_b), .StallE(StallE_b),
        .FlushD(FlushD_b), .FlushE(FlushE_b), .FlushM(FlushM_b), .MCBusy(MCBusy_b),
        .StallCnt(StallCnt_b), .FlushCnt(FlushCnt_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // m_age: cycles the current multi-cycle op has spent in E (-1 = none).
    int P_FWD[2] = '{1, 0};
    int P_LAT[2] = '{4, 1};
    int P_MAX[2] = '{65535, 7};
    int m_age[2];
    int m_sc[2];
    int m_fc[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_age[k] = -1;
            m_sc[k]  = 0;
            m_fc[k]  = 0;
        end
    endtask

    function automatic logic [1:0] m_fwd(input int fwd_en, input logic [4:0] rs);
        if (fwd_en == 0 || rs == 0) return 2'b00;
        if (RegWriteM && RD_M == rs) return 2'b10;
        if (RegWriteW && RD_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_busy(input int k);
        // The op stays in E for P_LAT cycles; upstream is frozen for all but the last.
        if (m_age[k] < 0) return MCStartE && (P_LAT[k] > 1);
        return m_age[k] < P_LAT[k] - 1;
    endfunction

    function automatic logic [10:0] model_out(input int k);
        logic [4:0] srcs[2];
        logic       haz, busy;
        logic       sf, sd, se, fd, fe, fm;
        srcs[0] = Rs1_D;
        srcs[1] = Rs2_D;
        haz = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (srcs[i] != 0) begin
                if (P_FWD[k] != 0) begin
                    if (RegWriteE && ResultSrcE && srcs[i] == RD_E) haz = 1'b1;
                end else if ((RegWriteE && srcs[i] == RD_E) || (RegWriteM && srcs[i] == RD_M)) begin
                    haz = 1'b1;
                end
            end
        end
        busy = m_busy(k);
        {sf, sd, se, fd, fe, fm} = 6'b0;
        if (busy)        {sf, sd, se, fm} = 4'b1111;
        else if (PCSrcE) {fd, fe} = 2'b11;
        else if (haz)    {sf, sd, fe} = 3'b111;
        return {m_fwd(P_FWD[k], Rs1_E), m_fwd(P_FWD[k], Rs2_E), sf, sd, se, fd, fe, fm, busy};
    endfunction

    // Settle, compare both instances with the model, then advance the model one clock.
    task automatic eval(input string tag);
        logic [10:0] e;
        logic        b;
        #1;
        check({tag, "_outA"}, 32'(outA), 32'(model_out(0)));
        check({tag, "_outB"}, 32'(outB), 32'(model_out(1)));
        check({tag, "_stallcntA"}, 32'(StallCnt_a), m_sc[0]);
        check({tag, "_flushcntA"}, 32'(FlushCnt_a), m_fc[0]);
        check({tag, "_stallcntB"}, 32'(StallCnt_b), m_sc[1]);
        check({tag, "_flushcntB"}, 32'(FlushCnt_b), m_fc[1]);
        for (int k = 0; k < 2; k++) begin
            e = model_out(k);
            b = m_busy(k);
            if (e[6] && m_sc[k] < P_MAX[k]) m_sc[k]++;
            if (PCSrcE && !b && m_fc[k] < P_MAX[k]) m_fc[k]++;
            if (m_age[k] < 0 && b) m_age[k] = 0;
            if (m_age[k] >= 0) begin
                m_age[k]++;
                if (m_age[k] >= P_LAT[k]) m_age[k] = -1;
            end
        end
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        {Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W} = '0;
        {RegWriteE, ResultSrcE, MCStartE, PCSrcE, RegWriteM, RegWriteW} = '0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        int rwe, rse, rwm, rww, pcs;
        int fa, fb;      // instance A forwarding
        int ctl_a;       // {StallF,StallD,FlushD,FlushE} instance A
        int ctl_b;       // same for instance B
    } vec_t;

    vec_t tbl[12];

    initial begin
        int sc_before;

        tbl[0]  = '{0,0,5,0,0,5,5, 0,0,1,1,0, 'b10,'b00, 'b0000,'b0000};
        tbl[1]  = '{0,0,5,0,0,5,5, 0,0,0,1,0, 'b01,'b00, 'b0000,'b0000};
        tbl[2]  = '{0,0,0,0,0,0,0, 0,0,1,1,0, 'b00,'b00, 'b0000,'b0000};
        tbl[3]  = '{0,7,0,0,7,0,0, 1,1,0,0,0, 'b00,'b00, 'b1101,'b1101};
        tbl[4]  = '{0,7,0,0,7,0,0, 1,1,0,0,1, 'b00,'b00, 'b0011,'b0011};
        tbl[5]  = '{3,0,0,0,0,3,0, 0,0,1,0,0, 'b00,'b00, 'b0000,'b1101};
        tbl[6]  = '{0,0,0,9,0,4,9, 0,0,1,1,0, 'b00,'b01, 'b0000,'b0000};
        tbl[7]  = '{0,0,6,6,0,6,0, 0,0,1,0,0, 'b10,'b10, 'b0000,'b0000};
        tbl[8]  = '{0,0,0,0,0,0,0, 1,1,0,0,0, 'b00,'b00, 'b0000,'b0000};
        tbl[9]  = '{8,0,0,0,8,0,0, 1,0,0,0,0, 'b00,'b00, 'b0000,'b1101};
        tbl[10] = '{7,0,0,0,7,0,0, 0,1,0,0,0, 'b00,'b00, 'b0000,'b0000};
        tbl[11] = '{2,0,2,0,0,0,2, 0,0,0,1,0, 'b01,'b00, 'b0000,'b0000};

        model_reset();

        // Reset: every output low even with hazard-producing inputs.
        rst = 1'b0;
        clear_inputs();
        Rs1_E = 5; RD_M = 5; RegWriteM = 1'b1; PCSrcE = 1'b1;
        #1;
        check("rst_outA", 32'(outA), 0);
        check("rst_outB", 32'(outB), 0);
        check("rst_stallcntA", 32'(StallCnt_a), 0);
        check("rst_flushcntA", 32'(FlushCnt_a), 0);
        next();
        rst = 1'b1;

        foreach (tbl[i]) begin
            Rs1_D = 5'(tbl[i].rs1d); Rs2_D = 5'(tbl[i].rs2d);
            Rs1_E = 5'(tbl[i].rs1e); Rs2_E = 5'(tbl[i].rs2e);
            RD_E  = 5'(tbl[i].rde);  RD_M  = 5'(tbl[i].rdm);  RD_W = 5'(tbl[i].rdw);
            RegWriteE  = (tbl[i].rwe != 0); ResultSrcE = (tbl[i].rse != 0);
            RegWriteM  = (tbl[i].rwm != 0); RegWriteW  = (tbl[i].rww != 0);
            PCSrcE     = (tbl[i].pcs != 0); MCStartE   = 1'b0;
            eval("tbl");
            check($sformatf("tbl%0d_fwdA", i), 32'({ForwardAE_a, ForwardBE_a}), 32'((tbl[i].fa << 2) | tbl[i].fb));
            check($sformatf("tbl%0d_ctlA", i), 32'({StallF_a, StallD_a, FlushD_a, FlushE_a}), 32'(tbl[i].ctl_a));
            check($sformatf("tbl%0d_ctlB", i), 32'({StallF_b, StallD_b, FlushD_b, FlushE_b}), 32'(tbl[i].ctl_b));
            check($sformatf("tbl%0d_fwdB", i), 32'({ForwardAE_b, ForwardBE_b}), 0);
            next();
        end

        // Multi-cycle op held for MC_LAT=4 cycles: frozen 0..2, released at 3.
        clear_inputs();
        MCStartE = 1'b1;
        sc_before = 1;
        for (int c = 0; c < 4; c++) begin
            eval("mc");
            if (c == 0) begin
                check("tbl_stallcntA", 32'(StallCnt_a), 1);
                check("tbl_flushcntA", 32'(FlushCnt_a), 1);
                check("tbl_stallcntB", 32'(StallCnt_b), 3);
                check("tbl_flushcntB", 32'(FlushCnt_b), 1);
            end
            check($sformatf("mc%0d_busyA", c), 32'(MCBusy_a), 32'(c < 3));
            check($sformatf("mc%0d_frzA", c), 32'({StallF_a, StallD_a, StallE_a, FlushM_a, FlushD_a, FlushE_a}),
                  (c < 3) ? 32'b111100 : 32'b0);
            check($sformatf("mc%0d_busyB", c), 32'({MCBusy_b, StallF_b, StallE_b}), 0);
            next();
        end
        MCStartE = 1'b0;
        eval("mc_post");
        check("mc_post_busyA", 32'(MCBusy_a), 0);
        check("mc_stallcntA", 32'(StallCnt_a), 32'(sc_before + 3));
        next();

        // Reset asserted mid-freeze (counter at 2).
        clear_inputs();
        Rs1_E = 5; RD_M = 5; RegWriteM = 1'b1;
        MCStartE = 1'b1;
        eval("rstmc"); next();
        eval("rstmc"); next();
        eval("rstmc");
        check("rstmc_busy_before", 32'(MCBusy_a), 1);
        rst = 1'b0;
        #1;
        check("rstmc_outA", 32'(outA), 0);
        check("rstmc_cntA", 32'({StallCnt_a, FlushCnt_a}), 0);
        model_reset();
        next();
        rst = 1'b1;
        MCStartE = 1'b0;
        eval("rstmc_rel");
        check("rstmc_rel_busyA", 32'(MCBusy_a), 0);
        check("rstmc_rel_fwdA", 32'(ForwardAE_a), 32'b10);
        check("rstmc_rel_cntA", 32'({StallCnt_a, FlushCnt_a}), 0);
        next();

        // Interlock RAW against M held long enough to saturate the 3-bit counter.
        clear_inputs();
        Rs1_D = 3; RD_M = 3; RegWriteM = 1'b1;
        for (int c = 0; c < 10; c++) begin
            eval("sat");
            next();
        end
        eval("sat_end");
        check("sat_stallcntB", 32'(StallCnt_b), 7);
        check("sat_stallcntA", 32'(StallCnt_a), 0);
        next();

        // Randomized traffic on a small register range to force collisions.
        for (int i = 0; i < 400; i++) begin
            Rs1_D = 5'($urandom_range(0, 3)); Rs2_D = 5'($urandom_range(0, 3));
            Rs1_E = 5'($urandom_range(0, 3)); Rs2_E = 5'($urandom_range(0, 3));
            RD_E  = 5'($urandom_range(0, 3)); RD_M  = 5'($urandom_range(0, 3));
            RD_W  = 5'($urandom_range(0, 3));
            RegWriteE  = 1'($urandom_range(0, 1));
            ResultSrcE = 1'($urandom_range(0, 1));
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            MCStartE   = ($urandom_range(0, 5) == 0);
            PCSrcE     = !MCStartE && ($urandom_range(0, 6) == 0);
            eval("rnd");
            next();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
